// File: rtl/uart_word_arbiter.sv
// uart_word_arbiter: round-robin arbiter sharing one uart_tx_word transmitter among NUM_REQ word sources.
// Optional macro UART_ARB_FIXED_PRIO_EN: lowest-index requester always wins instead of round-robin.
module uart_word_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] req_word,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  tx_start,
    output logic [31:0]           tx_word,
    input  logic                  tx_idle,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic [15:0]           sent_count
);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT_LOW, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [31:0]          tx_word_q, tx_word_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [15:0]          sent_count_q, sent_count_d;
    logic                 win_valid;
    logic [IDW-1:0]       win_id;
    logic [IDW-1:0]       lo_id;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Winner is simply the lowest-index pending requester.
    always_comb begin
        lo_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) lo_id = IDW'(i);
        end
        win_valid = |req;
        win_id    = lo_id;
    end
`else
    logic [IDW-1:0] hi_id;
    logic           hi_valid;

    // Prefer the lowest pending index above the last grant; otherwise wrap to the lowest pending index.
    always_comb begin
        lo_id    = '0;
        hi_id    = '0;
        hi_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) lo_id = IDW'(i);
            if (req[i] && i > int'(grant_id_q)) begin
                hi_id    = IDW'(i);
                hi_valid = 1'b1;
            end
        end
        win_valid = |req;
        win_id    = hi_valid ? hi_id : lo_id;
    end
`endif

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        tx_start_d   = 1'b0;
        tx_word_d    = tx_word_q;
        grant_id_d   = grant_id_q;
        sent_count_d = sent_count_q;
        case (state_q)
            ARB: begin
                if (tx_idle && win_valid) begin
                    ack_d[win_id] = 1'b1;
                    tx_word_d     = req_word[32*win_id +: 32];
                    grant_id_d    = win_id;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                tx_start_d   = 1'b1;
                sent_count_d = sent_count_q + 16'd1;
                state_d      = WAIT_LOW;
            end
            WAIT_LOW:  state_d = tx_idle ? WAIT_LOW : WAIT_DONE;
            WAIT_DONE: state_d = tx_idle ? ARB : WAIT_DONE;
            default:   state_d = ARB;
        endcase
    end

    // State and output registers; reset clears everything immediately, dropping any pending grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB;
            ack_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_word_q    <= '0;
            grant_id_q   <= IDW'(NUM_REQ - 1);
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            tx_start_q   <= tx_start_d;
            tx_word_q    <= tx_word_d;
            grant_id_q   <= grant_id_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign ack        = ack_q;
    assign tx_start   = tx_start_q;
    assign tx_word    = tx_word_q;
    assign busy       = state_q != ARB;
    assign grant_id   = grant_id_q;
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_uart_word_arbiter.sv
// tb_uart_word_arbiter: directed self-checking bench for uart_word_arbiter.
module tb_uart_word_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_word;
    logic [3:0]   ack;
    logic         tx_start;
    logic [31:0]  tx_word;
    logic         tx_idle;
    logic         busy;
    logic [1:0]   grant_id;
    logic [15:0]  sent_count;

    int checks = 0;
    int errors = 0;

    uart_word_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_word(req_word), .ack(ack),
        .tx_start(tx_start), .tx_word(tx_word), .tx_idle(tx_idle), .busy(busy),
        .grant_id(grant_id), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int id, input logic [31:0] word);
        int n = 0;
        while (ack == 4'd0 && n < 20) begin
            step();
            n++;
        end
        check("ack_onehot", 32'(ack), 32'd1 << id);
        check("grant_id", 32'(grant_id), 32'(id));
        check("ack_no_start", 32'(tx_start), 32'd0);
        step();
        check("tx_start", 32'(tx_start), 32'd1);
        check("ack_cleared", 32'(ack), 32'd0);
        check("tx_word", tx_word, word);
        tx_idle = 1'b0;
        step();
        check("start_pulse_end", 32'(tx_start), 32'd0);
        step();
        check("busy_wait_done", 32'(busy), 32'd1);
        tx_idle = 1'b1;
        step();
        check("back_in_arb", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_word = '0;
        tx_idle  = 1'b1;
        repeat (2) step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        check("rst_sent_count", 32'(sent_count), 32'd0);
        rst = 1'b0;

        req             = 4'b0100;
        req_word[95:64] = 32'hDEADBEEF;
        serve(2, 32'hDEADBEEF);
        req = '0;
        check("single_sent_count", 32'(sent_count), 32'd1);

        tx_idle = 1'b0;
        req     = 4'b0010;
        repeat (2) begin
            step();
            check("withdraw_busy_ack", 32'(ack), 32'd0);
        end
        req     = '0;
        tx_idle = 1'b1;
        repeat (3) begin
            step();
            check("withdraw_ack", 32'(ack), 32'd0);
            check("withdraw_start", 32'(tx_start), 32'd0);
        end

        rst            = 1'b1;
        tx_idle        = 1'b0;
        req            = 4'b0001;
        req_word[31:0] = 32'h11111111;
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            check("idle_low_no_ack", 32'(ack), 32'd0);
            check("idle_low_arb", 32'(busy), 32'd0);
        end
        tx_idle = 1'b1;
        serve(0, 32'h11111111);
        check("late_idle_sent_count", 32'(sent_count), 32'd1);

        req_word = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        req      = 4'b0100;
        step();
        check("mid_ack", 32'(ack), 32'd4);
        req = '0;
        step();
        check("mid_start", 32'(tx_start), 32'd1);
        tx_idle = 1'b0;
        step();
        step();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_count", 32'(sent_count), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_start", 32'(tx_start), 32'd0);
        check("async_count", 32'(sent_count), 32'd0);
        check("async_grant", 32'(grant_id), 32'd3);
        check("async_word", tx_word, 32'd0);
        step();
        rst     = 1'b0;
        tx_idle = 1'b1;
        req     = 4'b1111;
        serve(0, 32'h11111111);
        serve(1, 32'h22222222);
        serve(2, 32'h33333333);
        serve(3, 32'h44444444);
        serve(0, 32'h11111111);
        check("rr_sent_count", 32'(sent_count), 32'd5);

        req = 4'b1001;
`ifdef UART_ARB_FIXED_PRIO_EN
        serve(0, 32'h11111111);
        serve(0, 32'h11111111);
        serve(0, 32'h11111111);
        req = 4'b1000;
        serve(3, 32'h44444444);
`else
        serve(3, 32'h44444444);
        serve(0, 32'h11111111);
        serve(3, 32'h44444444);
`endif
        req = '0;
        step();
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
